uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// first-word-fall-through receive FIFO with sticky frame-error and overrun flags.
module uart_rx #(
    parameter int unsigned DIV    = 16,
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned FDEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sIn,
    input  logic              dataRen,
    input  logic              errClr,
    output logic [DWIDTH-1:0] rxData,
    output logic              fifoEmpty,
    output logic              fifoFull,
    output logic              frameErr,
    output logic              overrun
);

    localparam int unsigned TW = $clog2(DIV);
    localparam int unsigned BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam int unsigned AW = $clog2(FDEPTH);
    localparam logic [TW-1:0] HalfLast = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] BitLast  = TW'(DIV - 1);
    localparam logic [BW-1:0] LastBit  = BW'(DWIDTH - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic              s_meta_q, s_sync_q;
    state_e            state_q;
    logic [TW-1:0]     timer_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [DWIDTH-1:0] shift_q;
    logic              stop_hit, push, ferr_set;

    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DWIDTH-1:0] mem_q [FDEPTH];
    logic              do_push, do_pop, ovr_set;
    logic              frame_err_q, frame_err_d, overrun_q, overrun_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_meta_q <= 1'b1;
            s_sync_q <= 1'b1;
        end else begin
            s_meta_q <= sIn;
            s_sync_q <= s_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!s_sync_q) begin
                        state_q <= StStart;
                        timer_q <= '0;
                    end
                end
                StStart: begin
                    if (timer_q == HalfLast) begin
                        // A start bit that is high again at mid-bit is a glitch.
                        state_q   <= s_sync_q ? StIdle : StData;
                        timer_q   <= '0;
                        bit_cnt_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StData: begin
                    if (timer_q == BitLast) begin
                        timer_q <= '0;
                        shift_q <= {s_sync_q, shift_q[DWIDTH-1:1]};
                        if (bit_cnt_q == LastBit) begin
                            state_q <= StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StStop: begin
                    if (timer_q == BitLast) begin
                        state_q <= StIdle;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        stop_hit    = (state_q == StStop) && (timer_q == BitLast);
        push        = stop_hit && s_sync_q;
        ferr_set    = stop_hit && !s_sync_q;
        fifoEmpty   = (wr_ptr_q == rd_ptr_q);
        fifoFull    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop      = dataRen && !fifoEmpty;
        // A pop in the same cycle frees the slot the push needs.
        do_push     = push && (!fifoFull || do_pop);
        ovr_set     = push && fifoFull && !do_pop;
        wr_ptr_d    = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        frame_err_d = ferr_set || (frame_err_q && !errClr);
        overrun_d   = ovr_set || (overrun_q && !errClr);
        rxData      = fifoEmpty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        frameErr    = frame_err_q;
        overrun     = overrun_q;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level model with a word queue and arrival schedule,
// compared every cycle, plus literal checks on key scenarios.
module tb_uart_rx;

    localparam int unsigned DIV = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned FD  = 32;
    // Falling edge driven after posedge P reaches the stop sample at this offset.
    localparam int unsigned LAT = 3 + DIV / 2 + (DW + 1) * DIV;

    typedef struct {
        int          due;
        logic [7:0]  data;
        logic        good;
    } ev_t;

    logic          clk, rst, sIn, dataRen, errClr;
    logic [DW-1:0] rxData;
    logic          fifoEmpty, fifoFull, frameErr, overrun;

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    ev_t           ev_q[$];
    logic [7:0]    mq[$];
    logic [7:0]    cap_q[$];
    logic          m_ferr = 1'b0;
    logic          m_ovr = 1'b0;
    logic          cap_en = 1'b0;

    uart_rx #(
        .DIV   (DIV),
        .DWIDTH(DW),
        .FDEPTH(FD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sIn      (sIn),
        .dataRen  (dataRen),
        .errClr   (errClr),
        .rxData   (rxData),
        .fifoEmpty(fifoEmpty),
        .fifoFull (fifoFull),
        .frameErr (frameErr),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: words arrive at their scheduled stop-sample edge; pops and flags
    // follow the buffer rules using the occupancy before the edge.
    initial begin : model
        ev_t ev;
        bit  pop_ok, push_ok, set_f, set_o;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                ev_q.delete();
                mq.delete();
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end else begin
                pop_ok  = dataRen && (mq.size() != 0);
                push_ok = 1'b0;
                set_f   = 1'b0;
                set_o   = 1'b0;
                if (ev_q.size() != 0 && ev_q[0].due == cyc) begin
                    ev = ev_q.pop_front();
                    if (!ev.good) set_f = 1'b1;
                    else if (mq.size() < FD || pop_ok) push_ok = 1'b1;
                    else set_o = 1'b1;
                end
                if (pop_ok) void'(mq.pop_front());
                if (push_ok) mq.push_back(ev.data);
                m_ferr = set_f || (m_ferr && !errClr);
                m_ovr  = set_o || (m_ovr && !errClr);
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("fifoEmpty", fifoEmpty, mq.size() == 0);
                chk("fifoFull", fifoFull, mq.size() == FD);
                chk("frameErr", frameErr, m_ferr);
                chk("overrun", overrun, m_ovr);
                if (mq.size() != 0) chk("rxData", rxData, mq[0]);
                if (cap_en && dataRen && !fifoEmpty) cap_q.push_back(rxData);
            end
        end
    end

    // Called and returns on a negedge; abort_bit >= 0 resets mid data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int abort_bit);
        ev_q.push_back('{due: cyc + LAT, data: d, good: stop_bit});
        sIn = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            sIn = d[k];
            if (k == abort_bit) begin
                repeat (2) @(negedge clk);
                rst = 1'b1;
                repeat (3) @(negedge clk);
                chk("rst_empty", fifoEmpty, 1);
                chk("rst_rxdata", rxData, 0);
                sIn = 1'b1;
                rst = 1'b0;
                return;
            end
            repeat (DIV) @(negedge clk);
        end
        sIn = stop_bit;
        repeat (DIV) @(negedge clk);
        sIn = 1'b1;
    endtask

    task automatic read_word(input string nm, input logic [7:0] exp);
        chk(nm, rxData, exp);
        dataRen = 1'b1;
        @(negedge clk);
        dataRen = 1'b0;
    endtask

    task automatic pulse_clr();
        errClr = 1'b1;
        @(negedge clk);
        errClr = 1'b0;
    endtask

    initial begin : stim
        rst = 1'b1; sIn = 1'b1; dataRen = 1'b0; errClr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_empty", fifoEmpty, 1);
        chk("reset_full", fifoFull, 0);
        chk("reset_ferr", frameErr, 0);
        chk("reset_ovr", overrun, 0);
        chk("reset_rxdata", rxData, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Good frame: visible exactly one cycle after the stop sample.
        send_frame(8'hA5, 1'b1, -1);
        chk("a5_not_yet", fifoEmpty, 1);
        @(negedge clk);
        chk("a5_visible", fifoEmpty, 0);
        chk("a5_frameerr", frameErr, 0);
        read_word("a5_data", 8'hA5);
        chk("a5_popped", fifoEmpty, 1);

        // One-clock glitch is rejected silently.
        sIn = 1'b0;
        @(negedge clk);
        sIn = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_empty", fifoEmpty, 1);
        chk("glitch_ferr", frameErr, 0);

        // Bad stop bit.
        send_frame(8'h3C, 1'b0, -1);
        @(negedge clk);
        chk("3c_ferr", frameErr, 1);
        chk("3c_empty", fifoEmpty, 1);
        pulse_clr();
        chk("3c_cleared", frameErr, 0);

        // Fill past capacity back-to-back, then push+pop while full.
        for (int i = 0; i <= 32; i++) send_frame(8'(i), 1'b1, -1);
        @(negedge clk);
        chk("fill_full", fifoFull, 1);
        chk("fill_ovr", overrun, 1);
        pulse_clr();
        chk("fill_ovr_clr", overrun, 0);
        send_frame(8'h40, 1'b1, -1);
        dataRen = 1'b1;
        @(negedge clk);
        dataRen = 1'b0;
        chk("pp_full", fifoFull, 1);
        chk("pp_ovr", overrun, 0);
        for (int k = 0; k < 32; k++) read_word("fill_data", (k < 31) ? 8'(k + 1) : 8'h40);
        chk("fill_drained", fifoEmpty, 1);

        // Reset mid-frame drops both the stored word and the frame in flight.
        send_frame(8'h99, 1'b1, -1);
        @(negedge clk);
        send_frame(8'hC3, 1'b1, 3);
        chk("abort_empty", fifoEmpty, 1);
        repeat (4) @(negedge clk);
        send_frame(8'h5A, 1'b1, -1);
        @(negedge clk);
        read_word("resume_data", 8'h5A);
        repeat (2) @(negedge clk);
        chk("resume_one_word", fifoEmpty, 1);

        // Back-to-back frames drained with dataRen held high.
        cap_en  = 1'b1;
        dataRen = 1'b1;
        @(negedge clk);
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        repeat (3) @(negedge clk);
        dataRen = 1'b0;
        cap_en  = 1'b0;
        chk("b2b_count", cap_q.size(), 2);
        if (cap_q.size() == 2) begin
            chk("b2b_first", cap_q[0], 8'h11);
            chk("b2b_second", cap_q[1], 8'h22);
        end
        chk("b2b_ferr", frameErr, 0);
        chk("b2b_ovr", overrun, 0);
        chk("b2b_empty", fifoEmpty, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
